// File: rtl/tb_clk_en_sequencer.sv
// tb_clk_en_sequencer: stretched reset and clk_en throttle generator for a downstream bench
// Ports: clk, sync_rst (sync active-high) | mode_i 00 on, 01 periodic, 10 random, 11 pause
//        out_sync_rst, out_clk_en, total_cycles (RUN cycles), enabled_cycles, limit_reached (sticky)
// Macro TB_RANDOM_STALL_EN compiles in the LFSR random-stall mode; without it mode 10 is always-on.
module tb_clk_en_sequencer #(
    parameter int          RESET_CYCLES    = 8,
    parameter int          EN_PERIOD       = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [7:0]  STALL_THRESHOLD = 8'd64,
    parameter int          CYCLE_LIMIT     = 256
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic [1:0]  mode_i,
    output logic        out_sync_rst,
    output logic        out_clk_en,
    output logic [31:0] total_cycles,
    output logic [31:0] enabled_cycles,
    output logic        limit_reached
);
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
    state_t      state, stateNext;
    logic [31:0] holdCnt, holdCntNext, phase, phaseNext, phaseAdv, totalNext, enabledNext;
    logic        rstNext, enNext, limitNext, modeEn, randEn;
`ifdef TB_RANDOM_STALL_EN
    logic [15:0] lfsr, lfsrNext, lfsrAdv;
    assign lfsrAdv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign randEn  = lfsrAdv[7:0] >= STALL_THRESHOLD;
`else
    logic unusedParams;
    assign unusedParams = ^{LFSR_SEED, STALL_THRESHOLD};
    assign randEn       = 1'b1;
`endif
    // Enables decode the post-advance phase so the first periodic enable lands on RUN cycle EN_PERIOD.
    assign phaseAdv = (phase == 32'(EN_PERIOD - 1)) ? 32'd0 : phase + 32'd1;
    assign modeEn   = mode_i == 2'b00 ? 1'b1 :
                      mode_i == 2'b01 ? phaseAdv == 32'(EN_PERIOD - 1) :
                      mode_i == 2'b10 ? randEn : 1'b0;
    always_comb begin
        stateNext   = state;
        holdCntNext = holdCnt;
        phaseNext   = phase;
        totalNext   = total_cycles;
        enabledNext = enabled_cycles;
        rstNext     = out_sync_rst;
        enNext      = 1'b0;
        limitNext   = limit_reached;
`ifdef TB_RANDOM_STALL_EN
        lfsrNext    = lfsr;
`endif
        case (state)
            HOLD: begin
                holdCntNext = holdCnt + 32'd1;
                if (holdCnt == 32'(RESET_CYCLES - 1)) begin
                    stateNext = RUN;
                    rstNext   = 1'b0;
                end
            end
            RUN: begin
                totalNext = total_cycles + 32'd1;
                phaseNext = phaseAdv;
`ifdef TB_RANDOM_STALL_EN
                lfsrNext  = lfsrAdv;
`endif
                enNext    = modeEn;
                if (out_clk_en) begin
                    enabledNext = enabled_cycles + 32'd1;
                    if (enabled_cycles == 32'(CYCLE_LIMIT - 1)) begin
                        stateNext = DONE;
                        limitNext = 1'b1;
                        enNext    = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state          <= HOLD;
            holdCnt        <= '0;
            phase          <= '0;
            total_cycles   <= '0;
            enabled_cycles <= '0;
            out_sync_rst   <= 1'b1;
            out_clk_en     <= 1'b0;
            limit_reached  <= 1'b0;
`ifdef TB_RANDOM_STALL_EN
            lfsr           <= LFSR_SEED;
`endif
        end else begin
            state          <= stateNext;
            holdCnt        <= holdCntNext;
            phase          <= phaseNext;
            total_cycles   <= totalNext;
            enabled_cycles <= enabledNext;
            out_sync_rst   <= rstNext;
            out_clk_en     <= enNext;
            limit_reached  <= limitNext;
`ifdef TB_RANDOM_STALL_EN
            lfsr           <= lfsrNext;
`endif
        end
    end
endmodule

// File: tb/tb_tb_clk_en_sequencer.sv
// tb_tb_clk_en_sequencer: directed self-checking bench for tb_clk_en_sequencer
module tb_tb_clk_en_sequencer;
    logic        clk = 1'b0;
    logic        sync_rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        outSyncRst, outClkEn, limitReached;
    logic [31:0] totalCycles, enabledCycles;
    int          nCompared = 0;
    int          nMismatched = 0;

    tb_clk_en_sequencer dut (
        .clk(clk), .sync_rst(sync_rst), .mode_i(mode),
        .out_sync_rst(outSyncRst), .out_clk_en(outClkEn),
        .total_cycles(totalCycles), .enabled_cycles(enabledCycles),
        .limit_reached(limitReached)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench sampling inside RUN cycle 1.
    task automatic startRun(input logic [1:0] m);
        sync_rst = 1'b1;
        mode = m;
        tick(2);
        sync_rst = 1'b0;
        tick(8);
    endtask

    initial begin
        logic        prevEn;
        int          hi;
        logic [15:0] l;
        logic        expEn, nextEn, done;
        int          cnt;
        tick(3);
        check("rst_sync_rst", outSyncRst, 1);
        check("rst_clk_en", outClkEn, 0);
        check("rst_total", totalCycles, 0);
        check("rst_enabled", enabledCycles, 0);
        check("rst_limit", limitReached, 0);
        sync_rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("stretch_%0d", k), outSyncRst, k <= 8);
            check($sformatf("first_en_%0d", k), outClkEn, k == 10);
            tick(1);
        end

        startRun(2'b01);
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("periodic_%0d", c), outClkEn, (c % 4) == 0);
            tick(1);
        end
        check("periodic_enabled", enabledCycles, 10);
        check("periodic_total", totalCycles, 40);

        startRun(2'b00);
        prevEn = 1'b0;
        for (int i = 0; i < 400 && !limitReached; i++) begin
            prevEn = outClkEn;
            tick(1);
        end
        check("limit_flag", limitReached, 1);
        check("limit_prev_en", prevEn, 1);
        check("limit_en", outClkEn, 0);
        check("limit_enabled", enabledCycles, 256);
        check("limit_total", totalCycles, 257);
        tick(20);
        check("done_enabled", enabledCycles, 256);
        check("done_total", totalCycles, 257);
        check("done_en", outClkEn, 0);
        check("done_limit", limitReached, 1);
        check("done_sync_rst", outSyncRst, 0);

        startRun(2'b00);
        for (int i = 0; i < 300 && enabledCycles != 100; i++) tick(1);
        check("mid_enabled", enabledCycles, 100);
        check("mid_total", totalCycles, 101);
        sync_rst = 1'b1;
        mode = 2'b11;
        tick(1);
        check("mid_rst_total", totalCycles, 0);
        check("mid_rst_enabled", enabledCycles, 0);
        check("mid_rst_sync_rst", outSyncRst, 1);
        check("mid_rst_en", outClkEn, 0);
        sync_rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            hi += int'(outSyncRst);
            tick(1);
        end
        check("mid_stretch_len", hi, 8);
        check("mid_stretch_end", outSyncRst, 0);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("pause_%0d", c), outClkEn, 0);
            tick(1);
        end
        check("pause_total", totalCycles, 10);
        check("pause_enabled", enabledCycles, 0);
        mode = 2'b00;
        tick(1);
        check("resume_en", outClkEn, 1);

        startRun(2'b10);
        l = 16'hACE1;
        expEn = 1'b0;
        done = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 1000; c++) begin
            check($sformatf("random_%0d", c), outClkEn, expEn);
            tick(1);
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
`ifdef TB_RANDOM_STALL_EN
            nextEn = l[7:0] >= 8'd64;
`else
            nextEn = 1'b1;
`endif
            if (expEn && !done) begin
                cnt++;
                if (cnt == 256) done = 1'b1;
            end
            expEn = done ? 1'b0 : nextEn;
        end
        check("random_enabled", enabledCycles, cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
